fp_compare_unit: RTL
====================

# fp_compare_unit

Parametrised, pipelined floating-point compare/min-max unit for the OoO FP execution cluster. It takes two IEEE-754 operands of configurable format and returns FEQ/FLT/FLE booleans or FMIN/FMAX values with RISC-V-correct NaN, signed-zero and exception-flag behaviour. Issue and writeback use a valid/ready handshake, carry a ROB tag, and honour a pipeline flush.

## Interface
- EXP_W, 8, exponent width
- MAN_W, 23, mantissa width; operand width W = 1+EXP_W+MAN_W
- PIPE, 1, register stages, legal 1..4
- TAG_W, 6, ROB tag width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all in-flight operations
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts the operation this cycle
- in_op  in  3  000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX, others reserved
- in_a, in_b  in  W  operands
- in_tag  in  TAG_W  ROB tag
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts the result
- out_result  out  W  result
- out_fflags  out  5  {NV,DZ,OF,UF,NX}; only NV is ever set
- out_tag  out  TAG_W  tag of the result

## Operation
- NaN: exponent all ones, mantissa ≠ 0. sNaN: mantissa MSB = 0. Zero: exponent and mantissa = 0. +0 and −0 compare equal.
- Ordered compare: signs differ → negative is less (unless both zero). Same sign → magnitude compare on bits [W-2:0], inverted when negative.
- FEQ: NaN → 0; NV only if either operand is sNaN.
- FLT/FLE: NaN → 0; NV if either operand is any NaN.
- FEQ/FLT/FLE result zero-extended to W.
- FMIN/FMAX:
  - Both NaN → canonical NaN (sign 0, exponent all ones, mantissa MSB 1, rest 0).
  - One NaN → the other operand.
  - NV if either operand is sNaN.
  - −0 is less than +0: FMIN(+0,−0) = −0, FMAX = +0.
- Reserved op: result 0, flags 0, tag passed through.
- Datapath computed combinationally in stage 0, then carried through PIPE registers with valid bits v[0..PIPE-1].

## Timing
- Reset values: out_valid 0, out_result 0, out_fflags 0, out_tag 0, all v[] 0. in_ready is 0 while rst = 1.
- Accept when in_valid && in_ready. Result appears exactly PIPE cycles later if the pipe does not stall. Throughput is 1 op/cycle.
- Stage k advances when !v[k+1] or stage k+1 advances. The last stage advances on out_ready. in_ready = !rst && !flush && (!v[0] || stage 0 advances).
- out_valid && !out_ready: out_result, out_fflags and out_tag held stable; no op dropped or duplicated. Bubbles collapse.
- flush: all v[] cleared at the next edge. An op offered in the flush cycle is not accepted. out_valid is 0 the cycle after.
- rst mid-operation: same as flush, and the output registers return to their reset values.
- Output registers update only on a valid advance; held otherwise.

## Configuration
- FCMP_CLASS_EN defined: op 101 = FCLASS on in_a; in_b is ignored.
  - Result is a 10-bit one-hot mask zero-extended to W: bit0 −inf, 1 −normal, 2 −subnormal, 3 −0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
  - Flags 0.
- FCMP_CLASS_EN not defined: op 101 is reserved (result 0, flags 0).

## Test plan
- PIPE=1, FLT a=0xBF800000 (−1.0), b=0x3F800000 (1.0) → out_result 1, flags 0, one cycle after accept; FLE of the same a,a → 1.
- FEQ 0x80000000 vs 0x00000000 → 1. FMIN of the same pair → 0x80000000. FMAX of the same pair → 0x00000000.
- FLT 0x7FC00000 vs 1.0 → 0, NV=1. FEQ with same → 0, NV=0. FEQ 0x7F800001 (sNaN) vs 1.0 → 0, NV=1. FMAX 0x7F800001 vs 0x40000000 → 0x40000000, NV=1. FMIN qNaN vs qNaN → 0x7FC00000.
- PIPE=3, 8 back-to-back ops with tags 0..7 and out_ready low for 4 cycles mid-stream → in_ready deasserts once the pipe is full. All 8 results emerge in order with matching tags, and outputs stay stable while stalled.
- Flush asserted with 3 ops in flight and in_valid=1 → that input is not accepted, out_valid=0 the next cycle, and a subsequent op returns normally. Repeat with rst in place of flush → all outputs at reset values.
- FCMP_CLASS_EN, FCLASS 0xFF800000 → 0x001. FCLASS 0x00000001 → 0x020. FCLASS 0x7FC00000 → 0x200. Without the macro, op 101 → 0.

Source files
------------

// File: rtl/fp_compare_unit.sv
// rtl/fp_compare_unit.sv - pipelined FP compare/min-max unit (optional FCLASS via FCMP_CLASS_EN)
module fp_compare_unit #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int PIPE  = 1,
    parameter int TAG_W = 6,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [4:0]       out_fflags,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] OP_FEQ    = 3'b000;
    localparam logic [2:0] OP_FLT    = 3'b001;
    localparam logic [2:0] OP_FLE    = 3'b010;
    localparam logic [2:0] OP_FMIN   = 3'b011;
    localparam logic [2:0] OP_FMAX   = 3'b100;
    localparam logic [2:0] OP_FCLASS = 3'b101;

    localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // operand field decode
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic             a_nan, b_nan, a_snan, b_snan, a_zero, b_zero;

    assign a_sign = in_a[W-1];
    assign b_sign = in_b[W-1];
    assign a_exp  = in_a[W-2:MAN_W];
    assign b_exp  = in_b[W-2:MAN_W];
    assign a_man  = in_a[MAN_W-1:0];
    assign b_man  = in_b[MAN_W-1:0];
    assign a_nan  = (&a_exp) && (|a_man);
    assign b_nan  = (&b_exp) && (|b_man);
    assign a_snan = a_nan && !a_man[MAN_W-1];
    assign b_snan = b_nan && !b_man[MAN_W-1];
    assign a_zero = (in_a[W-2:0] == '0);
    assign b_zero = (in_b[W-2:0] == '0);

    logic         s0_lt, s0_eq, s0_lt_mm, s0_nv;
    logic [W-1:0] s0_res;
    logic [9:0]   class_mask;

    // stage 0: ordered compare, NaN rules and result selection
    always_comb begin
        s0_lt      = 1'b0;
        s0_eq      = 1'b0;
        s0_lt_mm   = 1'b0;
        s0_nv      = 1'b0;
        s0_res     = '0;
        class_mask = '0;

        // +0 and -0 are equal for ordered compares; min/max treats -0 as smaller
        s0_eq = !(a_nan || b_nan) && ((in_a == in_b) || (a_zero && b_zero));
        if (a_sign != b_sign) begin
            s0_lt = a_sign && !(a_zero && b_zero);
        end else if (!a_sign) begin
            s0_lt = in_a[W-2:0] < in_b[W-2:0];
        end else begin
            s0_lt = in_b[W-2:0] < in_a[W-2:0];
        end
        s0_lt_mm = s0_lt || (a_zero && b_zero && a_sign && !b_sign);

        class_mask[0] = a_sign && (&a_exp) && (a_man == '0);
        class_mask[1] = a_sign && !(&a_exp) && (a_exp != '0);
        class_mask[2] = a_sign && (a_exp == '0) && (a_man != '0);
        class_mask[3] = a_sign && a_zero;
        class_mask[4] = !a_sign && a_zero;
        class_mask[5] = !a_sign && (a_exp == '0) && (a_man != '0);
        class_mask[6] = !a_sign && !(&a_exp) && (a_exp != '0);
        class_mask[7] = !a_sign && (&a_exp) && (a_man == '0);
        class_mask[8] = a_snan;
        class_mask[9] = a_nan && !a_snan;

        case (in_op)
            OP_FEQ: begin
                s0_res = {{(W-1){1'b0}}, s0_eq};
                s0_nv  = a_snan || b_snan;
            end
            OP_FLT: begin
                s0_res = {{(W-1){1'b0}}, s0_lt && !(a_nan || b_nan)};
                s0_nv  = a_nan || b_nan;
            end
            OP_FLE: begin
                s0_res = {{(W-1){1'b0}}, (s0_lt || s0_eq) && !(a_nan || b_nan)};
                s0_nv  = a_nan || b_nan;
            end
            OP_FMIN, OP_FMAX: begin
                s0_nv = a_snan || b_snan;
                if (a_nan && b_nan) begin
                    s0_res = CANON_NAN;
                end else if (a_nan) begin
                    s0_res = in_b;
                end else if (b_nan) begin
                    s0_res = in_a;
                end else if (in_op == OP_FMIN) begin
                    s0_res = s0_lt_mm ? in_a : in_b;
                end else begin
                    s0_res = s0_lt_mm ? in_b : in_a;
                end
            end
`ifdef FCMP_CLASS_EN
            OP_FCLASS: begin
                s0_res = {{(W-10){1'b0}}, class_mask};
            end
`else
            OP_FCLASS: begin
                s0_res = '0;
            end
`endif
            default: begin
                s0_res = '0;
                s0_nv  = 1'b0;
            end
        endcase
    end

    // pipeline state
    logic [PIPE-1:0] v_q, v_d;
    logic [PIPE-1:0] nv_q, nv_d;
    logic [W-1:0]     res_q [PIPE];
    logic [W-1:0]     res_d [PIPE];
    logic [TAG_W-1:0] tag_q [PIPE];
    logic [TAG_W-1:0] tag_d [PIPE];
    logic [PIPE-1:0]  adv;

    // stage k may move forward if any later stage is empty or the output is taken
    always_comb begin
        logic go;
        adv          = '0;
        go           = out_ready;
        adv[PIPE-1]  = go;
        for (int k = PIPE - 2; k >= 0; k--) begin
            go     = go || !v_q[k+1];
            adv[k] = go;
        end
    end

    assign in_ready = !rst && !flush && (!v_q[0] || adv[0]);

    // next-state for valid bits and stage payloads; payload only moves with a valid op
    always_comb begin
        v_d  = v_q;
        nv_d = nv_q;
        for (int k = 0; k < PIPE; k++) begin
            res_d[k] = res_q[k];
            tag_d[k] = tag_q[k];
        end

        if (in_ready) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                res_d[0] = s0_res;
                nv_d[0]  = s0_nv;
                tag_d[0] = in_tag;
            end
        end else if (adv[0]) begin
            v_d[0] = 1'b0;
        end

        for (int k = 1; k < PIPE; k++) begin
            if (adv[k-1]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    res_d[k] = res_q[k-1];
                    nv_d[k]  = nv_q[k-1];
                    tag_d[k] = tag_q[k-1];
                end
            end else if (adv[k]) begin
                v_d[k] = 1'b0;
            end
        end

        if (flush) begin
            v_d = '0;
        end
    end

    // register update with synchronous reset of all stages
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q  <= '0;
            nv_q <= '0;
            for (int k = 0; k < PIPE; k++) begin
                res_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            v_q  <= v_d;
            nv_q <= nv_d;
            for (int k = 0; k < PIPE; k++) begin
                res_q[k] <= res_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign out_valid  = v_q[PIPE-1];
    assign out_result = res_q[PIPE-1];
    assign out_fflags = {nv_q[PIPE-1], 4'b0000};
    assign out_tag    = tag_q[PIPE-1];

endmodule
